btb_update_ctrl: RTL and testbench

- Branch target buffer (BTB) with a built-in update sequencer for the 5-stage pipeline.
- Serves the combinational stage-1 lookup (hit, predict-taken, target) from per-entry 2-bit saturating counters.
- Queues stage-4 branch resolutions and commits each one to the table by read-modify-write through a single write port.
- Sequences a full-table clear on request; updates and clear are arbitrated by one FSM.

---
 rtl/btb_update_ctrl_if.sv | 28 ++
 rtl/btb_update_ctrl.sv | 174 +++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// Bundle between the fetch/execute pipeline (master) and the BTB with its update sequencer (slave).
// Update handshake: an update transfers on a rising edge where upd_valid and upd_ready are both 1; the master holds it otherwise.
interface btb_update_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] lookup_pc;
  logic              hit_s1;
  logic              p_s1;
  logic [ADDR_W-1:0] target_s1;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_taken;
  logic              upd_ready;
  logic              clear_req;
  logic              clear_busy;
  logic [1:0]        dbg_state;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, clear_req,
    input  hit_s1, p_s1, target_s1, upd_ready, clear_busy, dbg_state
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_target, upd_taken, clear_req,
    output hit_s1, p_s1, target_s1, upd_ready, clear_busy, dbg_state
  );
endinterface

// File: rtl/btb_update_ctrl.sv
// Direct-mapped BTB with 2-bit counters; stage-4 resolutions are queued and committed by
// read-modify-write, and a full-table clear is walked one entry per cycle by the same FSM.
module btb_update_ctrl #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 32,
  parameter int QDEPTH  = 2
) (
  input logic              clk,
  input logic              rst_n,
  btb_update_ctrl_if.slave bus
);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int QP_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QC_W  = $clog2(QDEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_valid [ENTRIES];
  logic [TAG_W-1:0]  r_tag   [ENTRIES];
  logic [ADDR_W-1:0] r_tgt   [ENTRIES];
  logic [1:0]        r_ctr   [ENTRIES];

  logic [ADDR_W-1:0] r_q_pc  [QDEPTH];
  logic [ADDR_W-1:0] r_q_tgt [QDEPTH];
  logic              r_q_tkn [QDEPTH];
  logic [QP_W-1:0]   r_wr_ptr;
  logic [QP_W-1:0]   r_rd_ptr;
  logic [QC_W-1:0]   r_count;
  logic              r_clear_pend;
  logic [IDX_W-1:0]  r_walk;

  logic [IDX_W-1:0]  r_w_idx;
  logic [TAG_W-1:0]  r_w_tag;
  logic [ADDR_W-1:0] r_w_tgt;
  logic              r_w_tkn;
  logic              r_w_hit;
  logic [1:0]        r_w_ctr;

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_lk_hit;
  logic              w_clear_busy;
  logic              w_full;
  logic              w_empty;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_hd_pc;
  logic [IDX_W-1:0]  w_hd_idx;
  logic [TAG_W-1:0]  w_hd_tag;
  logic              w_unused;

  assign w_lk_idx     = bus.lookup_pc[IDX_W+1:2];
  assign w_lk_tag     = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign w_clear_busy = r_clear_pend | (r_state == ST_CLEAR);
  assign w_lk_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag) && !w_clear_busy;

  assign bus.hit_s1     = w_lk_hit;
  assign bus.p_s1       = w_lk_hit & r_ctr[w_lk_idx][1];
  assign bus.target_s1  = w_lk_hit ? r_tgt[w_lk_idx] : '0;
  assign bus.clear_busy = w_clear_busy;
  assign bus.dbg_state  = r_state;

  // Ready is independent of a same-cycle pop so it never combinationally loops through the FSM.
  assign w_full      = (r_count == QC_W'(QDEPTH));
  assign w_empty     = (r_count == '0);
  assign w_ready     = !w_full && !r_clear_pend && (r_state != ST_CLEAR);
  assign bus.upd_ready = w_ready;
  assign w_push      = bus.upd_valid && w_ready;
  assign w_pop       = (r_state == ST_IDLE) && !w_empty;

  assign w_hd_pc  = r_q_pc[r_rd_ptr];
  assign w_hd_idx = w_hd_pc[IDX_W+1:2];
  assign w_hd_tag = w_hd_pc[ADDR_W-1:IDX_W+2];
  assign w_unused = ^{bus.lookup_pc[1:0], w_hd_pc[1:0]};

  function automatic logic [QP_W-1:0] next_ptr(input logic [QP_W-1:0] p);
    return (p == QP_W'(QDEPTH - 1)) ? '0 : p + QP_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_clear_pend <= 1'b0;
      r_walk       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_w_idx      <= '0;
      r_w_tag      <= '0;
      r_w_tgt      <= '0;
      r_w_tkn      <= 1'b0;
      r_w_hit      <= 1'b0;
      r_w_ctr      <= 2'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_tgt[i]   <= '0;
        r_ctr[i]   <= 2'd0;
      end
      for (int j = 0; j < QDEPTH; j++) begin
        r_q_pc[j]  <= '0;
        r_q_tgt[j] <= '0;
        r_q_tkn[j] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_q_pc[r_wr_ptr]  <= bus.upd_pc;
        r_q_tgt[r_wr_ptr] <= bus.upd_target;
        r_q_tkn[r_wr_ptr] <= bus.upd_taken;
        r_wr_ptr          <= next_ptr(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + QC_W'(1);
        2'b01:   r_count <= r_count - QC_W'(1);
        default: r_count <= r_count;
      endcase

      if (r_state == ST_CLEAR) begin
        if (r_walk == IDX_W'(ENTRIES - 1)) r_clear_pend <= 1'b0;
      end else if (bus.clear_req) begin
        r_clear_pend <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_clear_pend && w_empty) begin
            r_state <= ST_CLEAR;
            r_walk  <= '0;
          end else if (!w_empty) begin
            r_w_idx <= w_hd_idx;
            r_w_tag <= w_hd_tag;
            r_w_tgt <= r_q_tgt[r_rd_ptr];
            r_w_tkn <= r_q_tkn[r_rd_ptr];
            r_w_hit <= r_valid[w_hd_idx] && (r_tag[w_hd_idx] == w_hd_tag);
            r_w_ctr <= r_ctr[w_hd_idx];
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // Entry snapshot taken at pop is safe: nothing else writes the table between pop and commit.
          if (r_w_hit) begin
            if (r_w_tkn) begin
              r_ctr[r_w_idx] <= (r_w_ctr == 2'd3) ? 2'd3 : r_w_ctr + 2'd1;
              r_tgt[r_w_idx] <= r_w_tgt;
            end else begin
              r_ctr[r_w_idx] <= (r_w_ctr == 2'd0) ? 2'd0 : r_w_ctr - 2'd1;
            end
          end else if (r_w_tkn) begin
            r_valid[r_w_idx] <= 1'b1;
            r_tag[r_w_idx]   <= r_w_tag;
            r_tgt[r_w_idx]   <= r_w_tgt;
            r_ctr[r_w_idx]   <= 2'd2;
          end
          r_state <= ST_IDLE;
        end
        ST_CLEAR: begin
          r_valid[r_walk] <= 1'b0;
          r_ctr[r_walk]   <= 2'd0;
          r_walk          <= r_walk + IDX_W'(1);
          if (r_walk == IDX_W'(ENTRIES - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: counter saturation, allocation/aliasing, FIFO back-pressure,
// clear sequencing and reset during a clear, with hand-computed expectations.
module tb_btb_update_ctrl;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  btb_update_ctrl_if #(.ADDR_W(32)) bus ();

  btb_update_ctrl #(
    .ENTRIES(16),
    .IDX_W  (4),
    .ADDR_W (32),
    .QDEPTH (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic p, input logic [31:0] tgt);
    bus.lookup_pc = pc;
    #1;
    check_eq({tag, "_hit"}, bus.hit_s1, hit);
    check_eq({tag, "_p"}, bus.p_s1, p);
    check_eq({tag, "_tgt"}, bus.target_s1, tgt);
  endtask

  task automatic send_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn);
    int t = 0;
    bus.upd_pc     = pc;
    bus.upd_target = tgt;
    bus.upd_taken  = tkn;
    bus.upd_valid  = 1'b1;
    #1;
    while (!bus.upd_ready && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) check_eq("upd_ready_timeout", 32'd0, 32'd1);
    step();
    bus.upd_valid = 1'b0;
  endtask

  task automatic commit_upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tkn);
    send_upd(pc, tgt, tkn);
    step();
    step();
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st);
    int t = 0;
    while (bus.dbg_state != st && t < 50) begin
      step();
      t++;
    end
    if (t >= 50) check_eq({tag, "_timeout"}, {30'd0, bus.dbg_state}, {30'd0, st});
  endtask

  logic [31:0] b_pc  [4] = '{32'h1004, 32'h2008, 32'h300C, 32'h300C};
  logic [31:0] b_tgt [4] = '{32'hA00, 32'hB00, 32'hC00, 32'hDDD};
  logic        b_tkn [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic        b_rdy [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int k;
    int cyc;
    int ccnt;
    int t;
    logic acc;

    rst_n          = 1'b0;
    bus.lookup_pc  = 32'h40;
    bus.upd_valid  = 1'b0;
    bus.upd_pc     = '0;
    bus.upd_target = '0;
    bus.upd_taken  = 1'b0;
    bus.clear_req  = 1'b0;
    repeat (2) step();
    check_eq("rst_hit", bus.hit_s1, 1'b0);
    check_eq("rst_p", bus.p_s1, 1'b0);
    check_eq("rst_tgt", bus.target_s1, 32'h0);
    check_eq("rst_ready", bus.upd_ready, 1'b1);
    check_eq("rst_busy", bus.clear_busy, 1'b0);
    check_eq("rst_state", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
    rst_n = 1'b1;
    step();

    // Counter walk on pc 0x40, including latency and both saturation points
    send_upd(32'h40, 32'h100, 1'b1);
    step();
    look("lat_before_commit", 32'h40, 1'b0, 1'b0, 32'h0);
    step();
    look("tk1_ctr2", 32'h40, 1'b1, 1'b1, 32'h100);
    commit_upd(32'h40, 32'h100, 1'b1);
    look("tk2_ctr3", 32'h40, 1'b1, 1'b1, 32'h100);
    commit_upd(32'h40, 32'h100, 1'b1);
    look("tk3_sat3", 32'h40, 1'b1, 1'b1, 32'h100);
    commit_upd(32'h40, 32'h999, 1'b0);
    look("nt1_ctr2", 32'h40, 1'b1, 1'b1, 32'h100);
    commit_upd(32'h40, 32'h999, 1'b0);
    look("nt2_ctr1", 32'h40, 1'b1, 1'b0, 32'h100);
    commit_upd(32'h40, 32'h999, 1'b0);
    look("nt3_ctr0", 32'h40, 1'b1, 1'b0, 32'h100);
    commit_upd(32'h40, 32'h999, 1'b0);
    look("nt4_sat0", 32'h40, 1'b1, 1'b0, 32'h100);
    commit_upd(32'h40, 32'h104, 1'b1);
    look("tk_from0_ctr1", 32'h40, 1'b1, 1'b0, 32'h104);

    // Not-taken miss does not allocate; taken alias replaces index 0
    commit_upd(32'h80, 32'h200, 1'b0);
    look("nt_miss_noalloc", 32'h80, 1'b0, 1'b0, 32'h0);
    look("nt_miss_keep", 32'h40, 1'b1, 1'b0, 32'h104);
    commit_upd(32'h80, 32'h200, 1'b1);
    look("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h80, 1'b1, 1'b1, 32'h200);
    commit_upd(32'h80, 32'h0, 1'b0);
    look("alias_alloc_ctr2", 32'h80, 1'b1, 1'b0, 32'h200);
    look("other_idx_miss", 32'h44, 1'b0, 1'b0, 32'h0);

    // Back-to-back: upd_valid held from an empty FIFO
    k   = 0;
    cyc = 0;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = b_pc[0];
    bus.upd_target = b_tgt[0];
    bus.upd_taken  = b_tkn[0];
    while (k < 4 && cyc < 20) begin
      #1;
      if (cyc < 4) check_eq($sformatf("b2b_ready_c%0d", cyc), bus.upd_ready, b_rdy[cyc]);
      acc = bus.upd_ready;
      step();
      if (acc) begin
        k++;
        if (k < 4) begin
          bus.upd_pc     = b_pc[k];
          bus.upd_target = b_tgt[k];
          bus.upd_taken  = b_tkn[k];
        end else begin
          bus.upd_valid = 1'b0;
        end
      end
      cyc++;
    end
    bus.upd_valid = 1'b0;
    check_eq("b2b_accepted", k, 4);
    repeat (8) step();
    look("b2b_a", 32'h1004, 1'b1, 1'b1, 32'hA00);
    look("b2b_b", 32'h2008, 1'b1, 1'b1, 32'hB00);
    look("b2b_cd_order", 32'h300C, 1'b1, 1'b0, 32'hC00);

    // Clear with one queued update
    send_upd(32'h4010, 32'hE00, 1'b1);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    bus.lookup_pc = 32'h1004;
    #1;
    check_eq("clr_busy_now", bus.clear_busy, 1'b1);
    check_eq("clr_ready_now", bus.upd_ready, 1'b0);
    check_eq("clr_drain_write", {30'd0, bus.dbg_state}, {30'd0, S_WRITE});
    check_eq("clr_pend_hit_forced", bus.hit_s1, 1'b0);
    step();
    check_eq("clr_after_commit", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
    check_eq("clr_busy_idle", bus.clear_busy, 1'b1);
    step();
    check_eq("clr_enter", {30'd0, bus.dbg_state}, {30'd0, S_CLEAR});
    bus.lookup_pc = 32'h4010;
    ccnt = 0;
    t    = 0;
    while (bus.clear_busy && t < 40) begin
      if (bus.dbg_state == S_CLEAR) ccnt++;
      check_eq($sformatf("clr_hit0_t%0d", t), bus.hit_s1, 1'b0);
      bus.clear_req = (t == 5);
      step();
      t++;
    end
    bus.clear_req = 1'b0;
    check_eq("clr_cycles", ccnt, 16);
    check_eq("clr_done_busy", bus.clear_busy, 1'b0);
    check_eq("clr_done_ready", bus.upd_ready, 1'b1);
    check_eq("clr_done_state", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
    look("clr_miss_1004", 32'h1004, 1'b0, 1'b0, 32'h0);
    look("clr_miss_2008", 32'h2008, 1'b0, 1'b0, 32'h0);
    look("clr_miss_300c", 32'h300C, 1'b0, 1'b0, 32'h0);
    look("clr_miss_4010", 32'h4010, 1'b0, 1'b0, 32'h0);
    look("clr_miss_80", 32'h80, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a clear walk
    commit_upd(32'h7C, 32'h700, 1'b1);
    look("pre_rst_idx15", 32'h7C, 1'b1, 1'b1, 32'h700);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    wait_state("rst_wait_clear", S_CLEAR);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", bus.clear_busy, 1'b0);
    check_eq("midrst_ready", bus.upd_ready, 1'b1);
    check_eq("midrst_state", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
    look("midrst_idx15", 32'h7C, 1'b0, 1'b0, 32'h0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check_eq("post_rst_idle", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
    check_eq("post_rst_busy", bus.clear_busy, 1'b0);
    commit_upd(32'h48, 32'h300, 1'b1);
    look("post_rst_upd", 32'h48, 1'b1, 1'b1, 32'h300);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
